// File: rtl/bus_mem_if.sv
// bus_mem_if: system-bus request/response bundle between a memory controller
// (master/initiator) and a memory target (slave/responder).
//   bus_reqcyc/bus_req/bus_reqtag : request beat (address, or write data)
//   bus_reqack                    : request beat accepted this cycle
//   bus_respcyc/bus_resp/bus_resptag : read response beat
//   bus_respack                   : initiator accepts the response beat
`timescale 1ns/1ps
interface bus_mem_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: memory-side target of the system bus. Accepts 64-byte
// block reads/writes, stores them in a word-addressed array and returns read
// data as an 8-beat tagged burst.
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : request/response bundle, see bus_mem_if
//   bd_we/addr/data  : backdoor word write, usable in any state
`timescale 1ns/1ps
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int RD_LATENCY     = 4,
  parameter int BEATS          = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  bus_mem_if.slave                     bus,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [BUS_DATA_WIDTH-1:0]    bd_data
);
  localparam int AW      = $clog2(MEM_WORDS);
  localparam int DIR_BIT = 12;  // tag bit 12: 1 = read, 0 = write

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_BURST} state_t;

  state_t                     r_state, w_state;
  logic [AW-1:3]              r_base,  w_base;   // 8-word aligned block index
  logic [BUS_TAG_WIDTH-1:0]   r_tag,   w_tag;
  logic [2:0]                 r_beat,  w_beat;
  logic [3:0]                 r_lat,   w_lat;
  logic                       r_respcyc, w_respcyc;
  logic [BUS_DATA_WIDTH-1:0]  r_resp,  w_resp;
  logic [BUS_TAG_WIDTH-1:0]   r_resptag, w_resptag;
  logic [BUS_DATA_WIDTH-1:0]  r_mem [MEM_WORDS];

  logic          w_reqack, w_xfer, w_mem_we;
  logic [2:0]    w_beat_inc;
  logic [AW-1:0] w_wr_idx;

  assign w_reqack   = bus.bus_reqcyc & ((r_state == IDLE) | (r_state == WR_DATA)) & ~reset;
  assign w_xfer     = bus.bus_reqcyc & w_reqack;
  assign w_beat_inc = r_beat + 3'd1;
  assign w_wr_idx   = {r_base, r_beat};

  assign bus.bus_reqack  = w_reqack;
  assign bus.bus_respcyc = r_respcyc;
  assign bus.bus_resp    = r_resp;
  assign bus.bus_resptag = r_resptag;

  always_comb begin
    w_state   = r_state;
    w_base    = r_base;
    w_tag     = r_tag;
    w_beat    = r_beat;
    w_lat     = r_lat;
    w_respcyc = r_respcyc;
    w_resp    = r_resp;
    w_resptag = r_resptag;
    w_mem_we  = 1'b0;
    case (r_state)
      IDLE: if (w_xfer) begin
        // Byte address -> word index bits [AW+2:3]; low 3 word bits dropped
        // to align to the block, upper bits dropped so deep addresses alias.
        w_base = bus.bus_req[AW+2:6];
        w_tag  = bus.bus_reqtag;
        w_beat = 3'd0;
        if (bus.bus_reqtag[DIR_BIT]) begin
          w_state = RD_WAIT;
          w_lat   = 4'(RD_LATENCY - 1);
        end else begin
          w_state = WR_DATA;
        end
      end
      WR_DATA: if (w_xfer) begin
        w_mem_we = 1'b1;
        w_beat   = w_beat_inc;   // wraps to 0 after beat 7
        if (r_beat == 3'd7) w_state = IDLE;
      end
      RD_WAIT: begin
        if (r_lat == 4'd0) begin
          w_state   = RD_BURST;
          w_respcyc = 1'b1;
          w_resp    = r_mem[{r_base, 3'd0}];
          w_resptag = r_tag;
          w_beat    = 3'd0;
        end else begin
          w_lat = r_lat - 4'd1;
        end
      end
      RD_BURST: if (bus.bus_respack) begin
        if (r_beat == 3'd7) begin
          w_state   = IDLE;
          w_respcyc = 1'b0;
          w_resp    = '0;
          w_resptag = '0;
          w_beat    = 3'd0;
        end else begin
          // Fetched at ack time so late backdoor writes still show up.
          w_beat = w_beat_inc;
          w_resp = r_mem[{r_base, w_beat_inc}];
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_tag     <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
    end else begin
      r_state   <= w_state;
      r_base    <= w_base;
      r_tag     <= w_tag;
      r_beat    <= w_beat;
      r_lat     <= w_lat;
      r_respcyc <= w_respcyc;
      r_resp    <= w_resp;
      r_resptag <= w_resptag;
    end
  end

  // Storage is never reset. Bus write is assigned last so it wins a
  // same-word collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we)    r_mem[bd_addr]  <= bd_data;
    if (w_mem_we) r_mem[w_wr_idx] <= bus.bus_req;
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
`timescale 1ns/1ps
module tb_bus_mem_responder;
  localparam int DW = 64, TW = 13, MW = 4096, AW = 12;

  logic          clk = 1'b0, reset = 1'b1;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  bus_mem_if #(.DW(DW), .TW(TW)) bif();

  bus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(MW),
    .RD_LATENCY(4), .BEATS(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bif),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] d0;
    int          stall_beat;
    int          stall_n;
  } rd_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input int idx, input logic [63:0] d);
    bd_we = 1'b1; bd_addr = AW'(idx); bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  // Expected beats must be pushed to exp_q by the caller before this runs.
  task automatic read_burst(input logic [63:0] addr, input logic [12:0] tag,
                            input int stall_beat, input int stall_n, input bit hold_req,
                            input int bd_beat, input int bd_idx, input logic [63:0] bd_val,
                            input int rst_beat);
    int lat;
    logic [63:0] e;
    bif.bus_reqcyc = 1'b1; bif.bus_req = addr; bif.bus_reqtag = tag;
    #1 chk("rd_reqack", 64'(bif.bus_reqack), 64'd1);
    tick();
    if (hold_req) begin bif.bus_req = 64'h40; bif.bus_reqtag = 13'h1ABC; end
    else bif.bus_reqcyc = 1'b0;
    lat = 0;
    while (!bif.bus_respcyc && lat < 64) begin
      if (hold_req) chk("hold_reqack_wait", 64'(bif.bus_reqack), 64'd0);
      tick(); lat++;
    end
    chk("rd_latency", 64'(lat), 64'd4);
    if (!bif.bus_respcyc) begin exp_q.delete(); bif.bus_reqcyc = 1'b0; return; end
    for (int b = 0; b < 8; b++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hBAD0_BAD0;
      chk("rd_data", bif.bus_resp, e);
      chk("rd_tag", 64'(bif.bus_resptag), 64'(tag));
      chk("rd_respcyc", 64'(bif.bus_respcyc), 64'd1);
      if (hold_req) chk("hold_reqack_burst", 64'(bif.bus_reqack), 64'd0);
      if (b == rst_beat) begin
        reset = 1'b1; bif.bus_reqcyc = 1'b1;
        #1 chk("rst_reqack", 64'(bif.bus_reqack), 64'd0);
        tick();
        chk("rst_respcyc", 64'(bif.bus_respcyc), 64'd0);
        chk("rst_resp", bif.bus_resp, 64'd0);
        chk("rst_resptag", 64'(bif.bus_resptag), 64'd0);
        reset = 1'b0; bif.bus_reqcyc = 1'b0;
        exp_q.delete();
        return;
      end
      if (b == stall_beat)
        for (int s = 0; s < stall_n; s++) begin
          bif.bus_respack = 1'b0;
          tick();
          chk("stall_data", bif.bus_resp, e);
          chk("stall_respcyc", 64'(bif.bus_respcyc), 64'd1);
        end
      if (b == bd_beat) begin bd_we = 1'b1; bd_addr = AW'(bd_idx); bd_data = bd_val; end
      bif.bus_respack = 1'b1;
      tick();
      bif.bus_respack = 1'b0; bd_we = 1'b0;
    end
    chk("end_respcyc", 64'(bif.bus_respcyc), 64'd0);
    chk("end_resp", bif.bus_resp, 64'd0);
    chk("end_resptag", 64'(bif.bus_resptag), 64'd0);
    if (hold_req) begin
      chk("hold_reqack_idle", 64'(bif.bus_reqack), 64'd1);
      bif.bus_reqcyc = 1'b0;
    end
  endtask

  task automatic write_block(input logic [63:0] addr, input logic [12:0] tag,
                             input logic [63:0] d0, input int gap_beat,
                             input int coll_beat, input logic [63:0] coll_val);
    int wbase;
    wbase = int'((addr >> 3) & 64'hFFF8) % MW;
    bif.bus_reqcyc = 1'b1; bif.bus_req = addr; bif.bus_reqtag = tag;
    #1 chk("wr_addr_ack", 64'(bif.bus_reqack), 64'd1);
    tick();
    for (int b = 0; b < 8; b++) begin
      if (b == gap_beat) begin
        bif.bus_reqcyc = 1'b0;
        #1 chk("wr_gap_ack", 64'(bif.bus_reqack), 64'd0);
        chk("wr_gap_respcyc", 64'(bif.bus_respcyc), 64'd0);
        tick();
      end
      bif.bus_reqcyc = 1'b1; bif.bus_req = d0 + 64'(b);
      if (b == coll_beat) begin bd_we = 1'b1; bd_addr = AW'(wbase + b); bd_data = coll_val; end
      #1 chk("wr_beat_ack", 64'(bif.bus_reqack), 64'd1);
      chk("wr_respcyc", 64'(bif.bus_respcyc), 64'd0);
      tick();
      bd_we = 1'b0;
    end
    bif.bus_reqcyc = 1'b0;
    #1 chk("wr_done_respcyc", 64'(bif.bus_respcyc), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_vec_t vecs[4];
    vecs[0] = '{64'h40,   13'h1ABC, 64'h1000, -1, 0};
    vecs[1] = '{64'h40,   13'h1003, 64'h1000,  2, 3};
    vecs[2] = '{64'h7F,   13'h1111, 64'h1000, -1, 0};
    vecs[3] = '{64'h8040, 13'h1222, 64'h1000, -1, 0};

    bif.bus_reqcyc = 1'b1; bif.bus_req = '0; bif.bus_reqtag = '0; bif.bus_respack = 1'b0;
    repeat (3) tick();
    chk("reset_reqack", 64'(bif.bus_reqack), 64'd0);
    chk("reset_respcyc", 64'(bif.bus_respcyc), 64'd0);
    chk("reset_resp", bif.bus_resp, 64'd0);
    chk("reset_resptag", 64'(bif.bus_resptag), 64'd0);
    bif.bus_reqcyc = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) bd_write(8 + i, 64'h1000 + 64'(i));
    for (int i = 0; i < 8; i++) bd_write(24 + i, 64'h3000 + 64'(i));

    // Aligned, stalled, unaligned and aliased reads of the preloaded block.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(vecs[v].d0 + 64'(i));
      read_burst(vecs[v].addr, vecs[v].tag, vecs[v].stall_beat, vecs[v].stall_n, 1'b0,
                 -1, 0, 64'd0, -1);
    end

    // Gapped write with a backdoor collision on word 18, then read-back.
    write_block(64'h80, 13'h0005, 64'hA0, 4, 2, 64'hDEAD);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'hA0 + 64'(i));
    read_burst(64'h80, 13'h1050, -1, 0, 1'b0, -1, 0, 64'd0, -1);

    // New request held high through a whole read.
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h1000 + 64'(i));
    read_burst(64'h40, 13'h1777, -1, 0, 1'b1, -1, 0, 64'd0, -1);

    // Backdoor write to a not-yet-sent word of an active burst.
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 5) ? 64'hBEEF : 64'h3000 + 64'(i));
    read_burst(64'hC0, 13'h1ACE, -1, 0, 1'b0, 0, 29, 64'hBEEF, -1);

    // Reset during beat 3, then a clean read.
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h1000 + 64'(i));
    read_burst(64'h40, 13'h1111, -1, 0, 1'b0, -1, 0, 64'd0, 3);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h1000 + 64'(i));
    read_burst(64'h40, 13'h1234, -1, 0, 1'b0, -1, 0, 64'd0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the core's system-bus interface: the far end of the request/response protocol driven by the core's memory controller.
- Accepts 64-byte block read and write requests, backs them with a word-addressed storage array, and returns read data as an 8-beat tagged burst.
- Instantiated in the simulation top and in the standalone memory-controller bench as the bus target. Also provides a backdoor preload port.

Parameters:
- BUS_DATA_WIDTH, 64, data/address beat width.
- BUS_TAG_WIDTH, 13, tag width; bit 12 = direction (1 read, 0 write).
- MEM_WORDS, 4096, storage depth in 64-bit words; must be a power of two and at least 8.
- RD_LATENCY, 4, cycles from read address acceptance to the first response beat; range 1..15.
- BEATS, 8, beats per block.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- bus_reqcyc  in  1  initiator request valid (address or write-data beat)
- bus_req  in  BUS_DATA_WIDTH  byte address (address phase) or write data (data phase)
- bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled in the address phase only
- bus_reqack  out  1  request beat accepted this cycle
- bus_respcyc  out  1  response beat valid
- bus_resp  out  BUS_DATA_WIDTH  read data beat
- bus_resptag  out  BUS_TAG_WIDTH  echo of the captured request tag
- bus_respack  in  1  initiator accepts the current response beat
- bd_we  in  1  backdoor word write enable
- bd_addr  in  $clog2(MEM_WORDS)  backdoor word index
- bd_data  in  BUS_DATA_WIDTH  backdoor write data

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is clk.
- Reset values: state IDLE, bus_respcyc 0, bus_resp 0, bus_resptag 0, beat counter 0, latency counter 0. bus_reqack is forced to 0 while reset is high. Storage contents are not cleared.
- States: IDLE, WR_DATA, RD_WAIT, RD_BURST.
- bus_reqack is combinational: it equals bus_reqcyc AND (state is IDLE or WR_DATA) AND NOT reset. A beat transfers on a clock edge where bus_reqcyc and bus_reqack are both 1.
- IDLE, on a transfer:
  - Capture the block base as bus_req[63:6], giving word index = (bus_req[63:3] & ~7) mod MEM_WORDS.
  - Capture bus_reqtag.
  - If tag[12] = 1, go to RD_WAIT and load the latency counter with RD_LATENCY-1.
  - If tag[12] = 0, go to WR_DATA with beat counter 0.
- WR_DATA:
  - Each transfer writes bus_req to word base+beat and increments the beat counter.
  - After the 8th beat (beat counter 7 transferred), return to IDLE and clear the beat counter.
  - No response phase for writes. bus_respcyc stays 0.
- RD_WAIT:
  - Decrement the latency counter each cycle.
  - When it is 0, go to RD_BURST on the next edge with bus_respcyc=1, bus_resp=mem[base+0], and bus_resptag set to the captured tag. First beat appears RD_LATENCY cycles after the address-accept edge.
- RD_BURST:
  - bus_resp and bus_resptag are held stable while bus_respack=0.
  - On an edge with bus_respack=1, advance to the next beat; bus_resp = mem[base+beat] registered.
  - After beat 7 is acked, bus_respcyc drops to 0, bus_resp and bus_resptag clear to 0, and the state returns to IDLE.
  - New requests are not acked during RD_WAIT or RD_BURST; the initiator holds bus_reqcyc.
- Beat order is linear: word base+0 through base+7, no critical-word-first.
- Address arithmetic:
  - Low 6 address bits are ignored.
  - Word index wraps modulo MEM_WORDS. An address beyond depth aliases; base+beat never crosses the block because base is 8-aligned.
- Backdoor writes:
  - bd_we writes bd_data to mem[bd_addr] in any state.
  - If a bus write targets the same word on the same edge, the bus write wins.
  - A backdoor write to a word not yet sent in an active read burst is visible in that burst.
- bus_respack while bus_respcyc=0 is ignored.
- bus_reqcyc in WR_DATA with the initiator abandoning the burst (reqcyc low) simply stalls; no timeout.
- Reset mid-operation, in any state: return to IDLE on the next edge, drop bus_respcyc and abort the burst. Words already written stay written.
- Back-to-back: a new address may be accepted in IDLE on the cycle immediately after the last read ack or the last write beat.

Test Plan:
- Preload via backdoor words 8..15 with 0x1000+i.
  - Read address 0x40, tag 0x1ABC.
  - Expected: reqack=1 on cycle 0; respcyc rises 4 cycles later; 8 beats 0x1000..0x1007 in order; resptag=0x1ABC on every beat.
- Read burst with respack held low 3 cycles on beat 2.
  - Expected: bus_resp stays 0x1002 and respcyc stays 1 until ack; total beats exactly 8.
- Write address 0x80, tag 0x0005, then 8 data beats 0xA0..0xA7 with reqcyc gapped on beat 4, then read 0x80.
  - Expected: reqack only on the 9 valid beats; read returns 0xA0..0xA7; respcyc never asserted during the write.
- Unaligned read 0x7F with MEM_WORDS=4096.
  - Expected: data from words 8..15.
  - Read 0x8040 (word 4104): aliases to words 8..15.
- Request during RD_BURST: reqcyc held high.
  - Expected: reqack=0 until the cycle after the 8th ack, then reqack=1 in IDLE.
- Assert reset during RD_BURST beat 3.
  - Expected: next edge respcyc=0, resp=0, resptag=0, state IDLE; a subsequent read completes normally with 8 beats.
